// File: rtl/blink_rate_ctrl.sv
// Blink rate controller: two debounced active-low keys step a saturating 3-bit
// rate index that selects the half-period of a one-cycle tick and a toggling led.
module blink_rate_ctrl #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned RATE_DEFAULT    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  output logic       tick,
  output logic       led,
  output logic [2:0] rate_idx
);

  localparam int unsigned     DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]     CLK_HZ_U = 32'(CLK_HZ);
  localparam logic [2:0]      RATE_RST = 3'(RATE_DEFAULT);

  // Bit 0 is the up key, bit 1 the down key throughout.
  logic [1:0]      w_key_n;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_stable;
  logic [1:0]      r_stable_d;
  logic [1:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [2];

  logic [2:0]      r_rate_idx;
  logic [2:0]      w_rate_next;
  logic            w_rate_chg;
  logic [31:0]     r_count;
  logic [31:0]     w_terminal;
  logic            r_tick;
  logic            r_led;

  assign w_key_n = {key_dn_n, key_up_n};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, giving the intended one-cycle pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_stable   <= '1;
      r_stable_d <= '1;
      r_press    <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it takes
      // the async reset like any other register.
      for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1    <= w_key_n;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable_d & ~r_stable;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_stable[k] <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // NOTE: default first, so every path assigns w_rate_next and no latch forms.
  always_comb begin
    w_rate_next = r_rate_idx;
    case (r_press)
      2'b01:   if (r_rate_idx != 3'd7) w_rate_next = r_rate_idx + 3'd1;
      2'b10:   if (r_rate_idx != 3'd0) w_rate_next = r_rate_idx - 3'd1;
      default: w_rate_next = r_rate_idx;
    endcase
  end

  // A press that saturates leaves the index alone and so does not restart the period.
  assign w_rate_chg = (w_rate_next != r_rate_idx);
  assign w_terminal = (CLK_HZ_U >> r_rate_idx) - 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate_idx <= RATE_RST;
      r_count    <= '0;
      r_tick     <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      r_rate_idx <= w_rate_next;
      if (w_rate_chg) begin
        r_count <= '0;
        r_tick  <= 1'b0;
      end else if (r_count == w_terminal) begin
        r_count <= '0;
        r_tick  <= 1'b1;
        r_led   <= ~r_led;
      end else begin
        r_count <= r_count + 32'd1;
        r_tick  <= 1'b0;
      end
    end
  end

  assign tick     = r_tick;
  assign led      = r_led;
  assign rate_idx = r_rate_idx;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Scoreboard bench for blink_rate_ctrl: directed key stimulus pushes hand-computed
// tick and rate-change events; a negedge monitor pops and compares them.
module tb_blink_rate_ctrl;

  localparam int CLK_HZ   = 64;
  localparam int DB       = 4;
  localparam int RATE_DEF = 3;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic       tick;
  logic       led;
  logic [2:0] rate_idx;

  blink_rate_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DB),
    .RATE_DEFAULT    (RATE_DEF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_up_n (key_up_n),
    .key_dn_n (key_dn_n),
    .tick     (tick),
    .led      (led),
    .rate_idx (rate_idx)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int led; } tick_exp_t;   // led < 0: not checked
  typedef struct { int cyc; int idx; } rate_exp_t;

  tick_exp_t  tick_q [$];
  rate_exp_t  rate_q [$];
  tick_exp_t  mon_te;
  rate_exp_t  mon_re;
  int         edge_cnt = 0;
  int         n_tests  = 0;
  int         n_fail   = 0;
  bit         tick_chk = 1'b0;
  logic [2:0] last_rate;
  logic       last_led;
  int         b;
  int         r;

  // Absolute rising-edge number; all expected cycles are expressed in it.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Monitor: led must change exactly on tick cycles; ticks and rate changes
  // are matched against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rate = rate_idx;
      last_led  = led;
    end else begin
      if (tick === 1'b1 || led !== last_led)
        check("led_toggles_with_tick", {tick, led}, {1'b1, ~last_led});
      if (tick_chk) begin
        if (tick === 1'b1) begin
          if (tick_q.size() == 0) begin
            flag("unexpected_tick", $sformatf("got tick at cycle %0d, expected none", edge_cnt));
          end else begin
            mon_te = tick_q.pop_front();
            check("tick_cycle", edge_cnt, mon_te.cyc);
            if (mon_te.led >= 0) check("tick_led", led, mon_te.led);
          end
        end else if (tick_q.size() > 0 && tick_q[0].cyc == edge_cnt) begin
          mon_te = tick_q.pop_front();
          flag("missed_tick", $sformatf("got no tick at cycle %0d, expected tick", edge_cnt));
        end
      end
      if (rate_idx !== last_rate) begin
        if (rate_q.size() == 0) begin
          flag("unexpected_rate_change",
               $sformatf("got rate %0d at cycle %0d, expected no change", rate_idx, edge_cnt));
        end else begin
          mon_re = rate_q.pop_front();
          check("rate_change_cycle", edge_cnt, mon_re.cyc);
          check("rate_change_value", rate_idx, mon_re.idx);
        end
        last_rate = rate_idx;
      end
      last_led = led;
    end
  end

  // Returns at #1 after rising edge t (inputs change there, sampled at t+1).
  task automatic wait_to(input int t);
    while (edge_cnt < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ticks(input int first, input int spacing, input int n, input int led_first);
    tick_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = first + i * spacing;
      e.led = (led_first < 0) ? -1 : (led_first ^ (i & 1));
      tick_q.push_back(e);
    end
  endtask

  task automatic push_rate(input int cyc, input int idx);
    rate_exp_t e;
    e.cyc = cyc;
    e.idx = idx;
    rate_q.push_back(e);
  endtask

  task automatic press(input bit up, input bit dn, input int t, input int len);
    wait_to(t);
    if (up) key_up_n = 1'b0;
    if (dn) key_dn_n = 1'b0;
    wait_to(t + len);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
  endtask

  task automatic end_ticks();
    check("tick_queue_drained", tick_q.size(), 0);
    tick_chk = 1'b0;
    tick_q.delete();
  endtask

  task automatic end_test();
    check("rate_queue_drained", rate_q.size(), 0);
    rate_q.delete();
  endtask

  // Reset is released at #1 after edge 'base', so the first tick is at base+8.
  task automatic apply_reset(output int base);
    int t;
    tick_chk = 1'b0;
    tick_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_tick", tick, 0);
    check("reset_led", led, 0);
    check("reset_rate", rate_idx, RATE_DEF);
    t = edge_cnt;
    wait_to(t + 2);
    rst_n = 1'b1;
    base = edge_cnt;
  endtask

  initial begin
    #200000;
    flag("watchdog", "got no end of run by 200000 time units, expected $finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: idle cadence at idx 3, TERMINAL 7.
    apply_reset(b);
    push_ticks(b + 8, 8, 4, 1);
    tick_chk = 1'b1;
    wait_to(b + 36);
    end_ticks();
    check("t1_rate", rate_idx, 3);
    end_test();

    // 2: up held 10 cycles from b+2 -> idx 4 at b+10, restart, spacing 4.
    apply_reset(b);
    push_ticks(b + 8, 8, 1, 1);
    push_rate(b + 10, 4);
    push_ticks(b + 14, 4, 3, 0);
    tick_chk = 1'b1;
    press(1'b1, 1'b0, b + 2, 10);
    wait_to(b + 24);
    end_ticks();
    check("t2_rate", rate_idx, 4);
    end_test();

    // 3: 3-cycle down glitch is rejected, cadence untouched.
    apply_reset(b);
    push_ticks(b + 8, 8, 3, 1);
    tick_chk = 1'b1;
    press(1'b0, 1'b1, b + 2, 3);
    wait_to(b + 26);
    end_ticks();
    check("t3_rate", rate_idx, 3);
    end_test();

    // 4: saturation. idx 7 is outside this clock's legal range (64>>7 == 0),
    // so every-cycle ticks are checked at idx 6 where TERMINAL is 0.
    apply_reset(b);
    for (int k = 0; k < 4; k++) push_rate(b + 10 + 16 * k, 4 + k);
    for (int k = 0; k < 7; k++) push_rate(b + 106 + 16 * k, 6 - k);
    push_ticks(b + 44, 1, 12, -1);
    press(1'b1, 1'b0, b + 2, 6);
    press(1'b1, 1'b0, b + 18, 6);
    press(1'b1, 1'b0, b + 34, 6);
    wait_to(b + 44);
    tick_chk = 1'b1;
    press(1'b1, 1'b0, b + 50, 6);
    end_ticks();
    press(1'b1, 1'b0, b + 66, 6);
    press(1'b1, 1'b0, b + 82, 6);
    wait_to(b + 96);
    check("t4_rate_sat_high", rate_idx, 7);
    for (int k = 0; k < 9; k++) press(1'b0, 1'b1, b + 98 + 16 * k, 6);
    wait_to(b + 240);
    push_ticks(b + 266, 64, 2, -1);
    tick_chk = 1'b1;
    wait_to(b + 336);
    end_ticks();
    check("t4_rate_sat_low", rate_idx, 0);
    end_test();

    // 5: both keys on the same edge: no rate change, no restart.
    apply_reset(b);
    push_ticks(b + 8, 8, 4, 1);
    tick_chk = 1'b1;
    press(1'b1, 1'b1, b + 2, 6);
    wait_to(b + 34);
    end_ticks();
    check("t5_rate", rate_idx, 3);
    end_test();

    // 6: reset at idx 5 mid-debounce with tick high; held key re-debounces.
    apply_reset(b);
    push_rate(b + 10, 4);
    push_rate(b + 26, 5);
    press(1'b1, 1'b0, b + 2, 6);
    press(1'b1, 1'b0, b + 18, 6);
    wait_to(b + 34);
    key_up_n = 1'b0;
    wait_to(b + 37);
    end_test();
    apply_reset(r);
    // Rate change at r+8 lands on the terminal count and suppresses that tick.
    push_rate(r + 8, 4);
    push_ticks(r + 12, 4, 2, 1);
    tick_chk = 1'b1;
    wait_to(r + 10);
    key_up_n = 1'b1;
    wait_to(r + 18);
    end_ticks();
    check("t6_rate", rate_idx, 4);
    end_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
